// File: rtl/imem_boot_arbiter.sv
// ---------------------------------------------------------------------------
// imem_boot_arbiter
// Sequences every access to the single-port instruction BSRAM.
//   * After reset, copies BOOT_WORDS words from a combinational boot ROM into
//     BSRAM, one word per cycle. The CPU is held during the copy.
//   * Spends one SETTLE cycle presenting cpu_addr so that the registered BSRAM
//     read is primed before the CPU is released.
//   * In RUN the CPU owns the memory address and fetches through cpu_dout.
//   * A loader can open an exclusive write session (ld_start) while in RUN.
//     The session halts the CPU until ld_end.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   boot_addr/boot_data   boot ROM address out / combinational data in
//   cpu_addr/cpu_dout     CPU fetch address in / fetched word out
//   cpu_run               CPU clock enable (high only in RUN)
//   ld_start/ld_end       open / close a loader session
//   ld_valid/ld_addr/
//   ld_data/ld_ready      loader write handshake
//   ld_count              words written in the current or last session
//   boot_done             sticky flag, set once the boot copy completes
//   busy                  high whenever the CPU is not running
//   mem_*                 Gowin_SP BSRAM macro interface
// ---------------------------------------------------------------------------
module imem_boot_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int BOOT_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_run,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_end,
  output logic [ADDR_W:0]   ld_count,
  output logic              boot_done,
  output logic              busy,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BOOT_LAST = ADDR_W'(BOOT_WORDS - 1);
  // ld_count saturates at the number of words in the memory (2**ADDR_W).
  localparam logic [ADDR_W:0]   LD_MAX    = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] boot_cnt_r;
  logic [ADDR_W:0]   ld_count_r;
  logic              boot_done_r;
  logic              boot_last_s;
  logic              ld_xfer_s;

  assign boot_last_s = (boot_cnt_r == BOOT_LAST);
  assign ld_xfer_s   = (state_r == ST_LOAD) && ld_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        if (boot_last_s) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_BOOT;
        end
      end
      ST_SETTLE: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (ld_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_end) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Output decode: memory port mux and status flags, with no added latency.
  always_comb begin
    mem_wre  = 1'b0;
    mem_ad   = cpu_addr;
    mem_din  = {DATA_W{1'b0}};
    cpu_run  = 1'b0;
    ld_ready = 1'b0;
    case (state_r)
      ST_BOOT: begin
        mem_wre = 1'b1;
        mem_ad  = boot_cnt_r;
        mem_din = boot_data;
      end
      ST_SETTLE: begin
        // Present the CPU address so the first RUN cycle sees valid data.
        mem_wre = 1'b0;
        mem_ad  = cpu_addr;
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        mem_ad  = cpu_addr;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        mem_wre  = ld_valid;
        mem_ad   = ld_addr;
        mem_din  = ld_data;
      end
      default: begin
        mem_wre = 1'b0;
      end
    endcase
  end

  // Boot copy address counter. It only advances while copying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt_r <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_BOOT) && !boot_last_s) begin
      boot_cnt_r <= boot_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky boot-complete flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_done_r <= 1'b0;
    end else if ((state_r == ST_BOOT) && boot_last_s) begin
      boot_done_r <= 1'b1;
    end
  end

  // Session word counter: cleared when a session opens, held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_count_r <= {(ADDR_W+1){1'b0}};
    end else if ((state_r == ST_RUN) && ld_start) begin
      ld_count_r <= {(ADDR_W+1){1'b0}};
    end else if (ld_xfer_s && (ld_count_r != LD_MAX)) begin
      ld_count_r <= ld_count_r + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign boot_addr = boot_cnt_r;
  assign cpu_dout  = mem_dout;
  assign busy      = ~cpu_run;
  assign ld_count  = ld_count_r;
  assign boot_done = boot_done_r;
  assign mem_ce    = 1'b1;
  assign mem_oce   = 1'b1;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
module tb_imem_boot_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_data;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_run;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              ld_end = 1'b0;
  logic [ADDR_W:0]   ld_count;
  logic              boot_done;
  logic              busy;
  logic              mem_ce;
  logic              mem_oce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  int tests_run = 0;
  int failed = 0;

  // Boot ROM stand-in: word i = 16'hA000 + i.
  assign boot_data = 16'hA000 + {5'd0, boot_addr};

  // Single-port BSRAM stand-in with a registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_dout_q = '0;
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) mem[mem_ad] <= mem_din;
      else         mem_dout_q  <= mem[mem_ad];
    end
  end
  assign mem_dout = mem_dout_q;

  always #5 clk = ~clk;

  imem_boot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .boot_addr(boot_addr), .boot_data(boot_data),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_run(cpu_run),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_end(ld_end), .ld_count(ld_count), .boot_done(boot_done),
    .busy(busy), .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values, then the full boot copy with ld_start held high (ignored).
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (cpu_run !== 1'b0) begin failed++; $display("FAIL rst_cpu_run: got %0b want 0", cpu_run); end
    tests_run++; if (ld_ready !== 1'b0) begin failed++; $display("FAIL rst_ld_ready: got %0b want 0", ld_ready); end
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL rst_busy: got %0b want 1", busy); end
    tests_run++; if (mem_wre !== 1'b1) begin failed++; $display("FAIL rst_mem_wre: got %0b want 1", mem_wre); end
    tests_run++; if (boot_done !== 1'b0) begin failed++; $display("FAIL rst_boot_done: got %0b want 0", boot_done); end
    tests_run++; if (ld_count !== 12'd0) begin failed++; $display("FAIL rst_ld_count: got %0d want 0", ld_count); end
    tests_run++; if ({mem_ce, mem_oce} !== 2'b11) begin failed++; $display("FAIL rst_ce_oce: got %b want 11", {mem_ce, mem_oce}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_start = (i < 15);
      tests_run++; if (mem_wre !== 1'b1) begin failed++; $display("FAIL boot_wre[%0d]: got %0b want 1", i, mem_wre); end
      tests_run++; if (mem_ad !== 11'(i)) begin failed++; $display("FAIL boot_ad[%0d]: got %0d want %0d", i, mem_ad, i); end
      tests_run++; if (mem_din !== 16'hA000 + 16'(i)) begin failed++; $display("FAIL boot_din[%0d]: got %h want %h", i, mem_din, 16'hA000 + 16'(i)); end
      tests_run++; if (cpu_run !== 1'b0) begin failed++; $display("FAIL boot_cpu_run[%0d]: got %0b want 0", i, cpu_run); end
      step();
    end
    ld_start = 1'b0;
    #1;
    // Cycle 17: SETTLE.
    tests_run++; if (mem_wre !== 1'b0) begin failed++; $display("FAIL settle_wre: got %0b want 0", mem_wre); end
    tests_run++; if (cpu_run !== 1'b0) begin failed++; $display("FAIL settle_cpu_run: got %0b want 0", cpu_run); end
    tests_run++; if (boot_done !== 1'b1) begin failed++; $display("FAIL settle_boot_done: got %0b want 1", boot_done); end
    tests_run++; if (ld_ready !== 1'b0) begin failed++; $display("FAIL settle_ld_ready: got %0b want 0", ld_ready); end
    step();
    // Cycle 18: RUN, and no session was opened by the boot-time ld_start.
    tests_run++; if (cpu_run !== 1'b1) begin failed++; $display("FAIL run_cpu_run: got %0b want 1", cpu_run); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL run_busy: got %0b want 0", busy); end
    step();
    tests_run++; if (ld_ready !== 1'b0) begin failed++; $display("FAIL run_no_session: got %0b want 0", ld_ready); end
  endtask

  // Address sweep in RUN: data lags by one cycle, no writes.
  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      cpu_addr = 11'(i);
      #1;
      tests_run++; if (mem_wre !== 1'b0) begin failed++; $display("FAIL sweep_wre[%0d]: got %0b want 0", i, mem_wre); end
      tests_run++; if (mem_ad !== 11'(i)) begin failed++; $display("FAIL sweep_ad[%0d]: got %0d want %0d", i, mem_ad, i); end
      step();
      tests_run++; if (cpu_dout !== 16'hA000 + 16'(i)) begin failed++; $display("FAIL sweep_dout[%0d]: got %h want %h", i, cpu_dout, 16'hA000 + 16'(i)); end
    end
  endtask

  // Load session with gaps; an ld_start pulse during LOAD must be ignored.
  task automatic test_load();
    logic [ADDR_W-1:0] la [3];
    logic [DATA_W-1:0] ldv [3];
    la[0] = 11'd5;   ldv[0] = 16'h1234;
    la[1] = 11'd6;   ldv[1] = 16'h5678;
    la[2] = 11'd100; ldv[2] = 16'h9ABC;
    ld_start = 1'b1;
    #1;
    tests_run++; if (cpu_run !== 1'b1) begin failed++; $display("FAIL load_pre_run: got %0b want 1", cpu_run); end
    step();
    ld_start = 1'b0;
    #1;
    tests_run++; if (cpu_run !== 1'b0) begin failed++; $display("FAIL load_cpu_run: got %0b want 0", cpu_run); end
    tests_run++; if (ld_ready !== 1'b1) begin failed++; $display("FAIL load_ready: got %0b want 1", ld_ready); end
    tests_run++; if (ld_count !== 12'd0) begin failed++; $display("FAIL load_count0: got %0d want 0", ld_count); end
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_addr = la[k]; ld_data = ldv[k];
      #1;
      tests_run++; if (mem_wre !== 1'b1) begin failed++; $display("FAIL load_wre[%0d]: got %0b want 1", k, mem_wre); end
      tests_run++; if ({mem_ad, mem_din} !== {la[k], ldv[k]}) begin failed++; $display("FAIL load_addr_data[%0d]: got %0d/%h want %0d/%h", k, mem_ad, mem_din, la[k], ldv[k]); end
      step();
      ld_valid = 1'b0;
      ld_start = (k == 0);
      #1;
      tests_run++; if (mem_wre !== 1'b0) begin failed++; $display("FAIL load_gap_wre[%0d]: got %0b want 0", k, mem_wre); end
      tests_run++; if (cpu_run !== 1'b0) begin failed++; $display("FAIL load_gap_run[%0d]: got %0b want 0", k, cpu_run); end
      step();
      ld_start = 1'b0;
    end
    #1;
    tests_run++; if (ld_count !== 12'd3) begin failed++; $display("FAIL load_count3: got %0d want 3", ld_count); end
    ld_end = 1'b1;
    step();
    ld_end = 1'b0;
    #1;
    tests_run++; if ({cpu_run, ld_ready, mem_wre} !== 3'b000) begin failed++; $display("FAIL load_settle: got %b want 000", {cpu_run, ld_ready, mem_wre}); end
    step();
    tests_run++; if (cpu_run !== 1'b1) begin failed++; $display("FAIL load_resume: got %0b want 1", cpu_run); end
    tests_run++; if (ld_count !== 12'd3) begin failed++; $display("FAIL load_count_hold: got %0d want 3", ld_count); end
    for (int k = 0; k < 3; k++) begin
      cpu_addr = la[k];
      step();
      tests_run++; if (cpu_dout !== ldv[k]) begin failed++; $display("FAIL load_readback[%0d]: got %h want %h", k, cpu_dout, ldv[k]); end
    end
    cpu_addr = 11'd7;
    step();
    tests_run++; if (cpu_dout !== 16'hA007) begin failed++; $display("FAIL load_untouched: got %h want a007", cpu_dout); end
  endtask

  // ld_valid together with ld_end: the word is still written and counted.
  task automatic test_end_with_valid();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_end = 1'b1; ld_addr = 11'd200; ld_data = 16'hBEEF;
    #1;
    tests_run++; if (mem_wre !== 1'b1) begin failed++; $display("FAIL endv_wre: got %0b want 1", mem_wre); end
    step();
    ld_valid = 1'b0; ld_end = 1'b0;
    #1;
    tests_run++; if (ld_count !== 12'd1) begin failed++; $display("FAIL endv_count: got %0d want 1", ld_count); end
    tests_run++; if ({cpu_run, ld_ready} !== 2'b00) begin failed++; $display("FAIL endv_settle: got %b want 00", {cpu_run, ld_ready}); end
    step();
    tests_run++; if (cpu_run !== 1'b1) begin failed++; $display("FAIL endv_run: got %0b want 1", cpu_run); end
    cpu_addr = 11'd200;
    step();
    tests_run++; if (cpu_dout !== 16'hBEEF) begin failed++; $display("FAIL endv_readback: got %h want beef", cpu_dout); end
  endtask

  // Async reset after two load writes: boot reruns and restores 0..15 only.
  task automatic test_reset_mid_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_addr = 11'd3; ld_data = 16'h1111;
    step();
    ld_addr = 11'd50; ld_data = 16'h2222;
    step();
    ld_valid = 1'b0;
    #1;
    tests_run++; if (ld_count !== 12'd2) begin failed++; $display("FAIL mid_count2: got %0d want 2", ld_count); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({cpu_run, ld_ready, boot_done} !== 3'b000) begin failed++; $display("FAIL mid_rst_flags: got %b want 000", {cpu_run, ld_ready, boot_done}); end
    tests_run++; if (ld_count !== 12'd0) begin failed++; $display("FAIL mid_rst_count: got %0d want 0", ld_count); end
    tests_run++; if ({mem_wre, mem_ad} !== {1'b1, 11'd0}) begin failed++; $display("FAIL mid_rst_port: got %0b/%0d want 1/0", mem_wre, mem_ad); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run++; if ({boot_done, mem_wre} !== 2'b01) begin failed++; $display("FAIL reboot_flags[%0d]: got %b want 01", i, {boot_done, mem_wre}); end
      tests_run++; if (mem_ad !== 11'(i)) begin failed++; $display("FAIL reboot_ad[%0d]: got %0d want %0d", i, mem_ad, i); end
      step();
    end
    tests_run++; if (boot_done !== 1'b1) begin failed++; $display("FAIL reboot_done: got %0b want 1", boot_done); end
    step();
    tests_run++; if (cpu_run !== 1'b1) begin failed++; $display("FAIL reboot_run: got %0b want 1", cpu_run); end
    cpu_addr = 11'd3;
    step();
    tests_run++; if (cpu_dout !== 16'hA003) begin failed++; $display("FAIL reboot_addr3: got %h want a003", cpu_dout); end
    cpu_addr = 11'd50;
    step();
    tests_run++; if (cpu_dout !== 16'h2222) begin failed++; $display("FAIL reboot_addr50: got %h want 2222", cpu_dout); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_load();
    test_end_with_valid();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
